// File: rtl/rv32_lsu.sv
// RV32I load/store unit: one outstanding access, alignment/opcode checks,
// byte-lane steering for stores, lane extraction/extension for loads, load timeout.
module rv32_lsu #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_mask,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FAULT} state_t;

  state_t        state_q, state_d;
  logic          is_load_q, is_load_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   addr_q, addr_d;
  logic [4:0]    rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          req_ready_q, req_ready_d;
  logic          bus_valid_q, bus_valid_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic          bus_we_q, bus_we_d;
  logic [3:0]    bus_mask_q, bus_mask_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic          wb_valid_q, wb_valid_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          fault_q, fault_d;
  logic [31:0]   fault_addr_q, fault_addr_d;

  logic          req_illegal;
  logic [3:0]    store_mask;
  logic [31:0]   store_data;
  logic [31:0]   lane_shifted;
  logic [31:0]   load_data;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    req_illegal = 1'b0;
    if (req_op == OP_LOAD) begin
      case (req_f3)
        3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
        3'b001, 3'b101:         req_illegal = req_addr[0];
        3'b010:                 req_illegal = (req_addr[1:0] != 2'b00);
        default:                req_illegal = 1'b0;
      endcase
    end else if (req_op == OP_STORE) begin
      case (req_f3)
        3'b000:  req_illegal = 1'b0;
        3'b001:  req_illegal = req_addr[0];
        3'b010:  req_illegal = (req_addr[1:0] != 2'b00);
        default: req_illegal = 1'b1;
      endcase
    end else begin
      req_illegal = 1'b1;
    end
  end

  // Store data is replicated across lanes so the bus needs no shifter; the mask selects.
  always_comb begin
    case (req_f3[1:0])
      2'b00: begin
        store_mask = 4'b0001 << req_addr[1:0];
        store_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        store_mask = 4'b0011 << req_addr[1:0];
        store_data = {2{req_wdata[15:0]}};
      end
      default: begin
        store_mask = 4'b1111;
        store_data = req_wdata;
      end
    endcase
  end

  assign lane_shifted = bus_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  load_data = {{24{lane_shifted[7]}}, lane_shifted[7:0]};
      3'b001:  load_data = {{16{lane_shifted[15]}}, lane_shifted[15:0]};
      3'b100:  load_data = {24'h000000, lane_shifted[7:0]};
      3'b101:  load_data = {16'h0000, lane_shifted[15:0]};
      default: load_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    is_load_d    = is_load_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    bus_valid_d  = bus_valid_q;
    bus_addr_d   = bus_addr_q;
    bus_we_d     = bus_we_q;
    bus_mask_d   = bus_mask_q;
    bus_wdata_d  = bus_wdata_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          is_load_d = (req_op == OP_LOAD);
          f3_d      = req_f3;
          addr_d    = req_addr;
          rd_d      = req_rd;
          if (req_illegal) begin
            state_d      = S_FAULT;
            fault_d      = 1'b1;
            fault_addr_d = req_addr;
          end else begin
            state_d     = S_REQ;
            bus_valid_d = 1'b1;
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_we_d    = (req_op != OP_LOAD);
            bus_mask_d  = (req_op == OP_LOAD) ? 4'b1111 : store_mask;
            bus_wdata_d = (req_op == OP_LOAD) ? 32'h0 : store_data;
          end
        end
      end
      S_REQ: begin
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          if (is_load_q) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        // Response is checked before the timeout so a last-cycle response still wins.
        if (bus_rvalid) begin
          state_d = S_IDLE;
          if (rd_q != 5'd0) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = load_data;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT)) begin
            state_d      = S_FAULT;
            fault_d      = 1'b1;
            fault_addr_d = addr_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      is_load_q    <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= 32'h0;
      rd_q         <= 5'd0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      bus_valid_q  <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_we_q     <= 1'b0;
      bus_mask_q   <= 4'b0000;
      bus_wdata_q  <= 32'h0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'h0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      is_load_q    <= is_load_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      bus_valid_q  <= bus_valid_d;
      bus_addr_q   <= bus_addr_d;
      bus_we_q     <= bus_we_d;
      bus_mask_q   <= bus_mask_d;
      bus_wdata_q  <= bus_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign bus_valid  = bus_valid_q;
  assign bus_addr   = bus_addr_q;
  assign bus_we     = bus_we_q;
  assign bus_mask   = bus_mask_q;
  assign bus_wdata  = bus_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_rv32_lsu.sv
// Directed plus randomized checks of rv32_lsu against an arithmetic reference model.
module tb_rv32_lsu;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = 5'd0;
  logic [2:0]  req_f3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_mask;
  logic [31:0] bus_wdata;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;
  logic [31:0] fault_addr;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_wb_data = 32'h0;
  logic [31:0] exp_fault_addr = 32'h0;

  rv32_lsu #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_f3(req_f3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_mask(bus_mask), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_illegal(input int op, input int f3, input int unsigned addr);
    if (op == 0) return (f3 == 3 || f3 == 6 || f3 == 7) || ((f3 == 1 || f3 == 5) && addr % 2 != 0)
                        || (f3 == 2 && addr % 4 != 0);
    if (op == 8) return (f3 >= 3) || (f3 == 1 && addr % 2 != 0) || (f3 == 2 && addr % 4 != 0);
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_mask(input int op, input int f3, input int unsigned addr);
    if (op == 0 || f3 == 2) return 32'd15;
    if (f3 == 0) return 32'(1 << (addr % 4));
    return 32'(3 << (addr % 4));
  endfunction

  function automatic logic [31:0] m_sdata(input int f3, input logic [31:0] wd);
    if (f3 == 0) return (wd & 32'hFF) * 32'h01010101;
    if (f3 == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input int unsigned addr, input logic [31:0] rd);
    longint v;
    v = longint'(rd >> (8 * (addr % 4)));
    case (f3)
      0: begin v = v % 256; if (v >= 128) v = v - 256; end
      1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      4: v = v % 256;
      5: v = v % 65536;
      default: v = longint'(rd);
    endcase
    return v[31:0];
  endfunction

  // One complete transaction starting from an IDLE cycle; returns in the next IDLE cycle.
  task automatic do_op(input int op, input int f3, input logic [31:0] addr, input logic [31:0] wd,
                       input int rd, input int rdy_dly, input int rv_dly, input logic [31:0] rdata);
    check("idle_ready", 32'(req_ready), 32'd1);
    check("wb_data_hold", wb_data, exp_wb_data);
    check("fault_addr_hold", fault_addr, exp_fault_addr);
    req_valid = 1'b1; req_op = 5'(op); req_f3 = 3'(f3); req_addr = addr; req_wdata = wd; req_rd = 5'(rd);
    @(negedge clock);
    req_valid = 1'b0; req_op = 5'($urandom); req_addr = $urandom;
    $display("op=%0d f3=%0d addr=%h wdata=%h rd=%0d rdy_dly=%0d rv_dly=%0d", op, f3, addr, wd, rd, rdy_dly, rv_dly);
    if (m_illegal(op, f3, addr)) begin
      exp_fault_addr = addr;
      check("ill_fault", 32'(fault), 32'd1);
      check("ill_fault_addr", fault_addr, addr);
      check("ill_bus_valid", 32'(bus_valid), 32'd0);
      check("ill_ready", 32'(req_ready), 32'd0);
      check("ill_wb", 32'(wb_valid), 32'd0);
      @(negedge clock);
      check("ill_fault_end", 32'(fault), 32'd0);
      return;
    end
    for (int k = 0; k <= rdy_dly; k++) begin
      check("req_bus_valid", 32'(bus_valid), 32'd1);
      check("req_ready_low", 32'(req_ready), 32'd0);
      check("req_bus_addr", bus_addr, addr & 32'hFFFFFFFC);
      check("req_bus_we", 32'(bus_we), 32'(op == 8));
      check("req_bus_mask", 32'(bus_mask), m_mask(op, f3, addr));
      if (op == 8) check("req_bus_wdata", bus_wdata, m_sdata(f3, wd));
      bus_ready = (k == rdy_dly);
      bus_rvalid = 1'($urandom);
      @(negedge clock);
    end
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    check("post_hs_valid", 32'(bus_valid), 32'd0);
    if (op == 8) return;
    if (rv_dly < TO) begin
      repeat (rv_dly) begin
        check("wait_ready", 32'(req_ready), 32'd0);
        check("wait_wb", 32'(wb_valid), 32'd0);
        @(negedge clock);
      end
      bus_rvalid = 1'b1; bus_rdata = rdata;
      @(negedge clock);
      bus_rvalid = 1'b0; bus_rdata = $urandom;
      check("resp_wb_valid", 32'(wb_valid), 32'(rd != 0));
      check("resp_fault", 32'(fault), 32'd0);
      if (rd != 0) begin
        exp_wb_data = m_load(f3, addr, rdata);
        check("resp_wb_rd", 32'(wb_rd), 32'(rd));
        check("resp_wb_data", wb_data, exp_wb_data);
      end
    end else begin
      repeat (TO) begin
        check("to_no_fault", 32'(fault), 32'd0);
        @(negedge clock);
      end
      exp_fault_addr = addr;
      check("to_fault", 32'(fault), 32'd1);
      check("to_fault_addr", fault_addr, addr);
      check("to_wb", 32'(wb_valid), 32'd0);
      @(negedge clock);
      check("to_fault_end", 32'(fault), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_bvalid"}, 32'(bus_valid), 32'd0);
    check({tag, "_we"}, 32'(bus_we), 32'd0);
    check({tag, "_mask"}, 32'(bus_mask), 32'd0);
    check({tag, "_baddr"}, bus_addr, 32'd0);
    check({tag, "_bwdata"}, bus_wdata, 32'd0);
    check({tag, "_wbv"}, 32'(wb_valid), 32'd0);
    check({tag, "_wbrd"}, 32'(wb_rd), 32'd0);
    check({tag, "_wbdata"}, wb_data, 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_faddr"}, fault_addr, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_reset_outputs("rst");

    do_op(8, 0, 32'h1003, 32'h000000A5, 0, 2, 0, 32'h0);
    do_op(0, 0, 32'h2002, 32'h0, 5, 0, 2, 32'h12F03456);
    @(negedge clock);
    check("wb_one_cycle", 32'(wb_valid), 32'd0);
    do_op(0, 4, 32'h2002, 32'h0, 5, 1, 2, 32'h12F03456);
    do_op(0, 2, 32'h2006, 32'h0, 3, 0, 0, 32'h0);
    do_op(0, 1, 32'h3002, 32'h0, 7, 0, 99, 32'h0);
    bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clock);
    bus_rvalid = 1'b0;
    check("late_rvalid_wb", 32'(wb_valid), 32'd0);

    // Reset in the middle of a load wait, then a stale response.
    req_valid = 1'b1; req_op = 5'd0; req_f3 = 3'd1; req_addr = 32'h4000; req_rd = 5'd9;
    @(negedge clock);
    req_valid = 1'b0; bus_ready = 1'b1;
    @(negedge clock);
    bus_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_wb_data = 32'h0; exp_fault_addr = 32'h0;
    check_reset_outputs("mid_rst");
    bus_rvalid = 1'b1; bus_rdata = 32'h55667788;
    @(negedge clock);
    bus_rvalid = 1'b0;
    check("stale_rvalid_wb", 32'(wb_valid), 32'd0);
    check("stale_rvalid_ready", 32'(req_ready), 32'd1);

    do_op(0, 2, 32'h5000, 32'h0, 0, 0, 1, 32'hCAFEF00D);
    do_op(8, 2, 32'h5004, 32'h11223344, 0, 0, 0, 32'h0);
    do_op(0, 2, 32'h5004, 32'h0, 12, 0, 0, 32'h11223344);
    do_op(0, 5, 32'h6002, 32'h0, 1, 0, TO - 1, 32'h8001C3D4);

    for (int i = 0; i < 60; i++) begin
      int sel, op;
      sel = $urandom_range(0, 9);
      op = (sel < 4) ? 0 : (sel < 8) ? 8 : $urandom_range(0, 31);
      do_op(op, $urandom_range(0, 7), {$urandom_range(0, 255), 2'(i), $urandom_range(0, 3)} & 32'h3FF,
            $urandom, $urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, TO + 1), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32_lsu.md
RV32_LSU -- requirements
Module: rv32_lsu

Interface
REQ-001 The block SHALL have one clock, `clock`, and a synchronous, active-high reset, `reset`.
REQ-002 Parameter `TIMEOUT`, default 64, SHALL set the maximum number of cycles spent waiting for load data.
REQ-003 Port `clock`, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port `reset`, input, 1 bit: synchronous active-high reset.
REQ-005 Port `req_valid`, input, 1 bit: upstream memory-op request.
REQ-006 Port `req_ready`, output, 1 bit: request accepted when `req_valid` and `req_ready` are both high.
REQ-007 Port `req_op`, input, 5 bits: opcode[6:2]; OP_LOAD=00000, OP_STORE=01000.
REQ-008 Port `req_f3`, input, 3 bits: funct3 using the RV32I F3_L*/F3_S* encodings.
REQ-009 Ports `req_addr` (input, 32 bits) and `req_wdata` (input, 32 bits): effective address and store data.
REQ-010 Port `req_rd`, input, 5 bits: load destination register.
REQ-011 Port `bus_valid`, output, 1 bit, and port `bus_ready`, input, 1 bit: bus request handshake.
REQ-012 Port `bus_addr`, output, 32 bits: word-aligned address with bits [1:0] = 00.
REQ-013 Port `bus_we`, output, 1 bit, and port `bus_mask`, output, 4 bits: write enable and byte-lane mask.
REQ-014 Port `bus_wdata`, output, 32 bits: lane-replicated store data.
REQ-015 Port `bus_rvalid`, input, 1 bit, and port `bus_rdata`, input, 32 bits: load response.
REQ-016 Ports `wb_valid` (output, 1 bit), `wb_rd` (output, 5 bits) and `wb_data` (output, 32 bits): load writeback.
REQ-017 Ports `fault` (output, 1 bit) and `fault_addr` (output, 32 bits): access fault pulse and offending address.

Function
REQ-018 The FSM SHALL have four states: IDLE, REQ, WAIT, FAULT; `req_ready` SHALL be high only in IDLE.
REQ-019 On accept in cycle N, the block SHALL register op, f3, addr, wdata and rd, then enter REQ, or FAULT if the request is illegal; the new state is visible in cycle N+1.
REQ-020 A request SHALL be illegal in any of these cases:
- op is neither LOAD nor STORE;
- load f3 is in {011, 110, 111};
- store f3 is >= 011;
- LH/LHU/SH with addr[0] = 1;
- LW/SW with addr[1:0] != 00.
REQ-021 FAULT SHALL last exactly one cycle: `fault` = 1, `fault_addr` = the registered address, no bus activity; then return to IDLE.
REQ-022 In REQ, `bus_valid` SHALL be 1 and `bus_addr`, `bus_we`, `bus_mask` and `bus_wdata` SHALL be held stable until the cycle in which `bus_ready` = 1.
REQ-023 Store byte mask SHALL be SB: 0001<<addr[1:0]; SH: 0011<<addr[1:0]; SW: 1111.
REQ-024 Store data SHALL be SB: wdata[7:0] replicated in all four lanes; SH: wdata[15:0] replicated in both halves; SW: wdata.
REQ-025 For loads, `bus_we` SHALL be 0 and `bus_mask` SHALL be 1111.
REQ-026 On a store handshake the FSM SHALL go to IDLE; on a load handshake it SHALL go to WAIT and clear the timeout counter.
REQ-027 `bus_rvalid` SHALL be ignored outside WAIT.
REQ-028 In WAIT, when `bus_rvalid` = 1:
- the lane at addr[1:0] SHALL be extracted from `bus_rdata`;
- LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, LW SHALL pass through;
- `wb_valid` SHALL be 1 for exactly the next cycle with `wb_rd` and `wb_data`, and the FSM SHALL return to IDLE.
REQ-029 A load with rd = 0 SHALL perform the bus access but SHALL NOT assert `wb_valid`.
REQ-030 In WAIT the counter SHALL increment each cycle without `bus_rvalid`; when it reaches TIMEOUT, the FSM SHALL go to FAULT.
REQ-031 If `bus_rvalid` arrives in the same cycle the counter reaches TIMEOUT, the data SHALL win (writeback, no fault).
REQ-032 `wb_valid` and `fault` SHALL never both be 1; outside their pulses `wb_valid` = 0 and `fault` = 0, and `wb_data`/`fault_addr` hold their last values.
REQ-033 Latency SHALL be: store accept to `bus_valid` = 1 cycle; `bus_rvalid` to `wb_valid` = 1 cycle; IDLE is re-entered the cycle after handshake or response.

Reset
REQ-034 When `reset` = 1 at a clock edge, the next state SHALL be IDLE with:
- `req_ready` = 1;
- `bus_valid`, `bus_we`, `wb_valid`, `fault` = 0;
- `bus_mask` = 0000;
- `bus_addr`, `bus_wdata`, `wb_data`, `wb_rd`, `fault_addr` = 0;
- timeout counter = 0.
REQ-035 Reset SHALL take priority over all other inputs and SHALL abandon any in-flight transaction.
REQ-036 A `bus_rvalid` for an abandoned transaction arriving after reset SHALL be ignored.

Verification
REQ-037 SB, addr=0x1003, wdata=0x000000A5, `bus_ready` delayed 2 cycles -> `bus_valid` held 3 cycles; then addr=0x1000, mask=1000, wdata=0xA5A5A5A5, we=1.
REQ-038 LB, addr=0x2002, rd=5, `bus_rdata`=0x12F03456 returned 3 cycles after handshake -> `wb_valid` 1 cycle, rd=5, data=0xFFFFFFF0; the same access with LBU -> data=0x000000F0.
REQ-039 LW, addr=0x2006 -> `fault` 1 cycle, `fault_addr`=0x2006, `bus_valid` never asserted, `req_ready` back next cycle.
REQ-040 LH, TIMEOUT=4, `bus_rvalid` never asserted -> `fault` after 4 WAIT cycles; then a late `bus_rvalid` in IDLE -> no `wb_valid`.
REQ-041 Reset asserted while in WAIT -> next cycle IDLE with all outputs at reset values; a following `bus_rvalid` is ignored.
REQ-042 Load with rd=0 and back-to-back SW/LW accepted on consecutive IDLE cycles -> bus access for both, no writeback for rd=0, ordering preserved.
